// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- instruction-fetch sequencer.
//
// Owns the program counter, issues one instruction-memory request at a time,
// presents each fetched word to decode with a valid/stall handshake and applies
// branch/jump redirects from execute.
//
// Optional feature macro: PC_WRAP_EN
//   defined   : next_pc(p) = RESET_PC when p+4 >= PC_LIMIT, else p+4
//   undefined : next_pc(p) = p+4 modulo 2^32 (PC_LIMIT unused)
//
// Parameters:
//   RESET_PC  PC after reset and the wrap target
//   PC_LIMIT  first address past the program region (wrap threshold)
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   stall                decode cannot accept the presented instruction
//   redirect_valid/_pc   one-cycle redirect; target bits [1:0] forced to 0
//   imem_req/_addr       fetch request (held until ack) and address (= pc)
//   imem_ack/_rdata      memory response
//   pc                   current fetch PC
//   inst_valid/inst/inst_pc  instruction presented to decode
//   issue_count          instructions accepted by decode (wraps at 2^32)

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    assign redir_tgt = redirect_pc & ~32'd3;
    assign pc_plus4  = pc_q + 32'd4;

`ifdef PC_WRAP_EN
    assign pc_next = (pc_plus4 >= PC_LIMIT) ? RESET_PC : pc_plus4;
`else
    assign pc_next = pc_plus4;
    logic unused_pc_limit;
    assign unused_pc_limit = ^PC_LIMIT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = redir_tgt;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // A redirect wins over a coincident ack: the returned word
                // belongs to the old path and is dropped.
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_next;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Redirect squashes the presented instruction even if stalled.
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them without an edge.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign inst_valid  = (state_q == S_ISSUE);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] LIMIT  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] issue_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: "boot" = the single dead cycle after reset, "hold" = a word is
    // sitting in front of decode; otherwise a request is outstanding.
    bit          m_boot;
    bit          m_hold;
    logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;

    pc_fetch_ctrl #(.RESET_PC(RST_PC), .PC_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p);
        logic [31:0] n;
        n = p + 32'd4;
`ifdef PC_WRAP_EN
        if (n >= LIMIT) n = RST_PC;
`endif
        return n;
    endfunction

    task automatic model_reset();
        m_boot = 1; m_hold = 0; m_pc = RST_PC;
        m_inst = '0; m_inst_pc = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        tgt = redirect_pc & ~32'd3;
        if (m_boot) begin
            if (redirect_valid) m_pc = tgt;
            m_boot = 0;
        end else if (!m_hold) begin
            if (redirect_valid) m_pc = tgt;
            else if (imem_ack) begin
                m_inst = imem_rdata; m_inst_pc = m_pc;
                m_pc = model_next(m_pc); m_hold = 1;
            end
        end else begin
            if (redirect_valid) begin
                m_pc = tgt; m_hold = 0;
            end else if (!stall) begin
                m_cnt = m_cnt + 1; m_hold = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_req",    {31'b0, imem_req},   {31'b0, !m_boot && !m_hold});
        check("imem_addr",   imem_addr,           m_pc);
        check("pc",          pc,                  m_pc);
        check("inst_valid",  {31'b0, inst_valid}, {31'b0, m_hold});
        check("inst",        inst,                m_inst);
        check("inst_pc",     inst_pc,             m_inst_pc);
        check("issue_count", issue_count,         m_cnt);
    endtask

    // Called at a negedge: drive inputs, take one rising edge, check at the
    // following negedge.
    task automatic cycle(input bit s, input bit r, input logic [31:0] rp,
                         input bit a, input logic [31:0] rd);
        stall = s; redirect_valid = r; redirect_pc = rp;
        imem_ack = a; imem_rdata = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge: asserts reset with a live ack, checks the outputs
    // clear without an edge, holds across one edge, releases at a negedge.
    task automatic do_reset();
        rst = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        #1;
        model_reset();
        check("rst_req_async", {31'b0, imem_req}, 32'd0);
        check("rst_pc_async",  pc,                RST_PC);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 0; imem_ack = 0;
    endtask

    initial begin
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        imem_ack = 0; imem_rdata = '0; rst = 0;
        @(negedge clk);
        do_reset();

        // zero-wait memory, no stall: three instructions in seven edges
        for (int i = 0; i < 7; i++) cycle(0, 0, '0, 1, 32'h1000_0000 + i);
        check("cnt_after_3", issue_count, 32'd3);

        // redirect to 0x10 coincident with ack, then ack delayed by 3 cycles
        cycle(0, 1, 32'h10, 1, 32'hBAD0_BAD0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0, '0);
        check("delay_req", {31'b0, imem_req}, 32'd1);
        check("delay_addr", imem_addr, 32'h10);
        cycle(0, 0, '0, 1, 32'hCAFE_0010);
        check("delay_inst_pc", inst_pc, 32'h10);
        check("delay_pc", pc, 32'h14);
        check("delay_inst", inst, 32'hCAFE_0010);

        // stall for 5 cycles, then redirect to 0x43 while still stalled
        for (int i = 0; i < 5; i++) cycle(1, 0, '0, 1, 32'h5555_5555);
        check("stall_cnt", issue_count, 32'd3);
        cycle(1, 1, 32'h43, 0, '0);
        check("squash_valid", {31'b0, inst_valid}, 32'd0);
        check("squash_addr", imem_addr, 32'h40);
        check("squash_cnt", issue_count, 32'd3);

        // fetch at 0xFC: the PC after it depends on the wrap option
        cycle(0, 1, 32'hFC, 0, '0);
        cycle(0, 0, '0, 1, 32'h0000_00FC);
`ifdef PC_WRAP_EN
        check("wrap_pc", pc, 32'h0);
`else
        check("wrap_pc", pc, 32'h100);
`endif
        cycle(0, 0, '0, 0, '0);

        // reset while a fetch waits at 0x20
        cycle(0, 1, 32'h20, 0, '0);
        cycle(0, 0, '0, 0, '0);
        cycle(0, 0, '0, 0, '0);
        check("wait_addr", imem_addr, 32'h20);
        do_reset();

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 8,
                      32'($urandom_range(0, 511)),
                      $urandom_range(0, 99) < 50,
                      32'($urandom()));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
